// File: rtl/seq_detector_param.sv
// Parametrised serial sequence detector: compares the last PAT_W qualified
// samples of w against a loadable pattern, pulses z and counts matches.
module seq_detector_param #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             load,
    input  logic [PAT_W-1:0] pattern_in,
    input  logic             overlap,
    input  logic             en,
    input  logic             w,
    input  logic             clr_cnt,
    output logic             z,
    output logic [CNT_W-1:0] match_count,
    output logic             cnt_sat,
    output logic             armed
);

    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [1:0] {
        UNLOADED = 2'd0,
        FILL     = 2'd1,
        RUN      = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PAT_W-1:0]   pat_q, pat_d;
    logic [PAT_W-1:0]   hist_q, hist_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic               z_q, z_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [PAT_W-1:0]   hist_shift;
    logic [FILL_W-1:0]  fill_inc;
    logic               sample;
    logic               match;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= UNLOADED;
            pat_q   <= '0;
            hist_q  <= '0;
            fill_q  <= '0;
            z_q     <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            z_q     <= z_d;
            count_q <= count_d;
        end
    end

    // load outranks en, so w is never sampled in a load cycle
    always_comb begin
        hist_shift = {hist_q[PAT_W-2:0], w};
        fill_inc   = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + 1'b1;
        sample     = !load && en && (state_q != UNLOADED);
        match      = sample && (hist_shift == pat_q) && (fill_inc == FILL_FULL);
    end

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        z_d     = 1'b0;

        if (load) begin
            pat_d   = pattern_in;
            hist_d  = '0;
            fill_d  = '0;
            state_d = FILL;
        end else if (sample) begin
            if (match) begin
                z_d = 1'b1;
                if (overlap) begin
                    hist_d  = hist_shift;
                    fill_d  = fill_inc;
                    state_d = RUN;
                end else begin
                    hist_d  = '0;
                    fill_d  = '0;
                    state_d = FILL;
                end
            end else begin
                hist_d  = hist_shift;
                fill_d  = fill_inc;
                state_d = (fill_inc == FILL_FULL) ? RUN : FILL;
            end
        end
    end

    // a clear in the same cycle as a match drops that match from the count
    always_comb begin
        count_d = count_q;
        if (clr_cnt) begin
            count_d = '0;
        end else if (match && (count_q != CNT_MAX)) begin
            count_d = count_q + 1'b1;
        end
    end

    assign z           = z_q;
    assign match_count = count_q;
    assign cnt_sat     = (count_q == CNT_MAX);
    assign armed       = (state_q != UNLOADED);

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: directed vector table followed by random
// stimulus compared against a sample-queue reference model.
module tb_seq_detector_param;

    localparam int PAT_W = 4;
    localparam int CNT_W = 3;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             Clk = 1'b0;
    logic             Rst;
    logic             load;
    logic [PAT_W-1:0] pattern_in;
    logic             overlap;
    logic             en;
    logic             w;
    logic             clr_cnt;
    logic             z;
    logic [CNT_W-1:0] match_count;
    logic             cnt_sat;
    logic             armed;

    int checks = 0;
    int errors = 0;

    seq_detector_param #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Rst(Rst), .load(load), .pattern_in(pattern_in),
        .overlap(overlap), .en(en), .w(w), .clr_cnt(clr_cnt),
        .z(z), .match_count(match_count), .cnt_sat(cnt_sat), .armed(armed)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic             rst;
        logic             ld;
        logic [PAT_W-1:0] pat;
        logic             ov;
        logic             en;
        logic             w;
        logic             clr;
        logic             exp_z;
        int               exp_cnt;
        logic             exp_armed;
    } vec_t;

    vec_t vecs[$];

    // Reference model: samples since the last restart, oldest first
    logic             m_armed;
    logic [PAT_W-1:0] m_pat;
    bit               m_samples[$];
    int               m_cnt;
    logic             m_z;

    function automatic vec_t mk(logic rst, logic ld, logic [PAT_W-1:0] pat, logic ov,
                                logic e, logic b, logic clr,
                                logic ez, int ec, logic ea);
        vec_t v;
        v.rst = rst; v.ld = ld; v.pat = pat; v.ov = ov; v.en = e; v.w = b; v.clr = clr;
        v.exp_z = ez; v.exp_cnt = ec; v.exp_armed = ea;
        return v;
    endfunction

    task automatic apply_stimulus(input vec_t v);
        Rst = v.rst; load = v.ld; pattern_in = v.pat; overlap = v.ov;
        en = v.en; w = v.w; clr_cnt = v.clr;
        @(posedge Clk);
        #1;
    endtask

    task automatic step_model();
        bit matched;
        logic [PAT_W-1:0] window;
        matched = 0;
        if (Rst) begin
            m_armed = 0; m_pat = '0; m_samples.delete(); m_cnt = 0; m_z = 0;
        end else begin
            if (load) begin
                m_pat = pattern_in;
                m_samples.delete();
                m_armed = 1;
            end else if (en && m_armed) begin
                m_samples.push_back(w);
                if (m_samples.size() > PAT_W) void'(m_samples.pop_front());
                if (m_samples.size() == PAT_W) begin
                    for (int i = 0; i < PAT_W; i++) window[PAT_W-1-i] = m_samples[i];
                    if (window == m_pat) begin
                        matched = 1;
                        if (!overlap) m_samples.delete();
                    end
                end
            end
            m_z = matched;
            if (clr_cnt) m_cnt = 0;
            else if (matched && m_cnt < CNT_MAX) m_cnt++;
        end
    endtask

    task automatic check_output(input string name, input int idx,
                                input logic ez, input int ec, input logic ea);
        logic es;
        es = (ec == CNT_MAX);
        checks += 4;
        if (z !== ez) begin
            errors++;
            $display("[TB] FAIL %s[%0d] z: got %b expected %b", name, idx, z, ez);
        end
        if (match_count !== CNT_W'(ec)) begin
            errors++;
            $display("[TB] FAIL %s[%0d] match_count: got %0d expected %0d", name, idx, match_count, ec);
        end
        if (cnt_sat !== es) begin
            errors++;
            $display("[TB] FAIL %s[%0d] cnt_sat: got %b expected %b", name, idx, cnt_sat, es);
        end
        if (armed !== ea) begin
            errors++;
            $display("[TB] FAIL %s[%0d] armed: got %b expected %b", name, idx, armed, ea);
        end
    endtask

    initial begin
        vec_t v;
        Rst = 1; load = 0; pattern_in = '0; overlap = 0; en = 0; w = 0; clr_cnt = 0;

        // Unloaded: samples ignored; then load in an en cycle drops that bit
        vecs.push_back(mk(1,0,4'b0000,0,0,0,0, 0,0,0));
        vecs.push_back(mk(0,0,4'b0000,1,1,1,0, 0,0,0));
        vecs.push_back(mk(0,0,4'b0000,1,1,0,0, 0,0,0));
        vecs.push_back(mk(0,0,4'b0000,1,1,1,0, 0,0,0));
        vecs.push_back(mk(0,0,4'b0000,1,1,1,0, 0,0,0));
        vecs.push_back(mk(0,1,4'b1011,1,1,1,0, 0,0,1));
        vecs.push_back(mk(0,0,4'b0000,1,1,1,0, 0,0,1));
        vecs.push_back(mk(0,0,4'b0000,1,1,0,0, 0,0,1));
        vecs.push_back(mk(0,0,4'b0000,1,1,1,0, 0,0,1));
        vecs.push_back(mk(0,0,4'b0000,1,1,1,0, 1,1,1));
        // Overlapping 1011 over 1,0,1,1,0,1,1
        vecs.push_back(mk(0,1,4'b1011,1,0,0,0, 0,1,1));
        vecs.push_back(mk(0,0,4'b0000,1,1,1,0, 0,1,1));
        vecs.push_back(mk(0,0,4'b0000,1,1,0,0, 0,1,1));
        vecs.push_back(mk(0,0,4'b0000,1,1,1,0, 0,1,1));
        vecs.push_back(mk(0,0,4'b0000,1,1,1,0, 1,2,1));
        vecs.push_back(mk(0,0,4'b0000,1,1,0,0, 0,2,1));
        vecs.push_back(mk(0,0,4'b0000,1,1,1,0, 0,2,1));
        vecs.push_back(mk(0,0,4'b0000,1,1,1,0, 1,3,1));
        // Non-overlapping: only the first window matches
        vecs.push_back(mk(0,1,4'b1011,0,0,0,0, 0,3,1));
        vecs.push_back(mk(0,0,4'b0000,0,1,1,0, 0,3,1));
        vecs.push_back(mk(0,0,4'b0000,0,1,0,0, 0,3,1));
        vecs.push_back(mk(0,0,4'b0000,0,1,1,0, 0,3,1));
        vecs.push_back(mk(0,0,4'b0000,0,1,1,0, 1,4,1));
        vecs.push_back(mk(0,0,4'b0000,0,1,0,0, 0,4,1));
        vecs.push_back(mk(0,0,4'b0000,0,1,1,0, 0,4,1));
        vecs.push_back(mk(0,0,4'b0000,0,1,1,0, 0,4,1));
        // 1111 with en toggling
        vecs.push_back(mk(0,1,4'b1111,1,0,0,0, 0,4,1));
        for (int i = 0; i < 7; i++)
            vecs.push_back(mk(0,0,4'b0000,1,(i % 2 == 0),1,0, (i == 6),(i == 6) ? 5 : 4,1));
        // Reset mid-stream, then samples ignored until reload
        vecs.push_back(mk(0,1,4'b1011,1,0,0,0, 0,5,1));
        vecs.push_back(mk(0,0,4'b0000,1,1,1,0, 0,5,1));
        vecs.push_back(mk(0,0,4'b0000,1,1,0,0, 0,5,1));
        vecs.push_back(mk(0,0,4'b0000,1,1,1,0, 0,5,1));
        vecs.push_back(mk(1,0,4'b0000,1,1,1,0, 0,0,0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0,0,4'b0000,1,1,1,0, 0,0,0));
        // Constant stream, clear on a match, saturation
        vecs.push_back(mk(0,1,4'b1111,1,0,0,0, 0,0,1));
        vecs.push_back(mk(0,0,4'b0000,1,1,1,0, 0,0,1));
        vecs.push_back(mk(0,0,4'b0000,1,1,1,0, 0,0,1));
        vecs.push_back(mk(0,0,4'b0000,1,1,1,0, 0,0,1));
        vecs.push_back(mk(0,0,4'b0000,1,1,1,0, 1,1,1));
        vecs.push_back(mk(0,0,4'b0000,1,1,1,1, 1,0,1));
        for (int i = 1; i <= 8; i++)
            vecs.push_back(mk(0,0,4'b0000,1,1,1,0, 1,(i > CNT_MAX) ? CNT_MAX : i,1));
        vecs.push_back(mk(0,0,4'b0000,1,0,1,0, 0,CNT_MAX,1));
        vecs.push_back(mk(0,0,4'b0000,1,0,1,1, 0,0,1));

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i]);
            step_model();
            check_output("vec", i, vecs[i].exp_z, vecs[i].exp_cnt, vecs[i].exp_armed);
        end

        // Random phase against the reference model
        v = mk(1,0,4'b0000,0,0,0,0, 0,0,0);
        apply_stimulus(v);
        step_model();
        check_output("rand_rst", 0, m_z, m_cnt, m_armed);
        v.ov = 1;
        for (int i = 0; i < 3000; i++) begin
            v.rst = ($urandom_range(0, 299) == 0);
            v.ld  = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 3) == 0)
                v.pat = ($urandom_range(0, 1) == 1) ? 4'b1111 : 4'b0000;
            else
                v.pat = PAT_W'($urandom);
            if ($urandom_range(0, 49) == 0) v.ov = ~v.ov;
            v.en  = ($urandom_range(0, 3) != 0);
            v.w   = ($urandom_range(0, 9) < 6);
            v.clr = ($urandom_range(0, 29) == 0);
            apply_stimulus(v);
            step_model();
            check_output("rand", i, m_z, m_cnt, m_armed);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
